conv_window_stream: RTL and testbench

- Streaming sliding-window generator that feeds the convolution datapath.
- Accepts one multi-channel pixel per cycle in raster order, buffers FILTER_SIZE-1 image rows, and emits FILTER_SIZE x FILTER_SIZE windows.
- Generalises the fixed-stride, always-valid front end with: independent X/Y strides, an in_valid gap-tolerant input, window coordinates, and end-of-frame markers.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/cnn_line_buffer.sv | 39 +++
 rtl/conv_window_stream.sv | 151 +++++++++++++++
 tb/tb_conv_window_stream.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared sizing helpers for the convolution front end: pixel/window bus widths,
// output-grid dimensions and counter widths.
package cnn_pkg;

    function automatic int pix_w(input int iw, input int ch);
        return iw * ch;
    endfunction

    function automatic int win_w(input int f, input int iw, input int ch);
        return f * f * iw * ch;
    endfunction

    function automatic int out_w(input int w, input int f, input int s);
        return (w - f) / s + 1;
    endfunction

    function automatic int out_h(input int h, input int f, input int s);
        return (h - f) / s + 1;
    endfunction

    // Never returns 0 so that degenerate counters (n == 1) still get a real bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// Single-row delay line: dout is the sample written exactly DEPTH enables ago.
// Latency: DEPTH enabled cycles; combinational read of the oldest entry.
// Backpressure: none; en gates every pointer and storage update.
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int AW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;

    // Read-before-write at the same slot gives exactly DEPTH entries of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en && !rst) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/conv_window_stream.sv
// Raster pixel stream in, strided FxF sliding windows out, with coordinates and frame markers.
// Latency: window_valid one enabled cycle after the accept that completes the window.
// Backpressure: none; in_valid gaps stall all state, clk_en low freezes everything.
module conv_window_stream
    import cnn_pkg::*;
#(
    parameter int I_WIDTH      = 8,
    parameter int CHANNELS_IN  = 3,
    parameter int FILTER_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int STRIDE_X     = 4,
    parameter int STRIDE_Y     = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  clk_en,
    input  logic                                                  in_valid,
    input  logic [pix_w(I_WIDTH, CHANNELS_IN)-1:0]                in_data,
    output logic [win_w(FILTER_SIZE, I_WIDTH, CHANNELS_IN)-1:0]   window_data,
    output logic                                                  window_valid,
    output logic [cnt_w(IMAGE_HEIGHT)-1:0]                        window_row,
    output logic [cnt_w(IMAGE_WIDTH)-1:0]                         window_col,
    output logic                                                  window_last,
    output logic                                                  frame_done
);

    localparam int PW     = pix_w(I_WIDTH, CHANNELS_IN);
    localparam int F      = FILTER_SIZE;
    localparam int RW     = cnt_w(IMAGE_HEIGHT);
    localparam int CW     = cnt_w(IMAGE_WIDTH);
    localparam int XPW    = cnt_w(STRIDE_X);
    localparam int YPW    = cnt_w(STRIDE_Y);
    localparam int LAST_R = (out_h(IMAGE_HEIGHT, F, STRIDE_Y) - 1) * STRIDE_Y;
    localparam int LAST_C = (out_w(IMAGE_WIDTH, F, STRIDE_X) - 1) * STRIDE_X;

    if (F < 1 || F > IMAGE_WIDTH || F > IMAGE_HEIGHT ||
        STRIDE_X < 1 || STRIDE_Y < 1 || CHANNELS_IN < 1) begin : g_bad_cfg
        $error("conv_window_stream: illegal parameter combination");
    end

    logic           accept;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [XPW-1:0] ph_x;
    logic [YPW-1:0] ph_y;
    logic           emit;
    logic           is_last;
    logic           is_end;

    logic [PW-1:0]  tap [F];
    logic [PW-1:0]  win [F][F];

    assign accept = clk_en && in_valid;

    // Phase counters only start once the window fits, so phase 0 marks a stride-aligned origin.
    assign emit    = accept && (row >= RW'(F - 1)) && (col >= CW'(F - 1)) &&
                     (ph_x == '0) && (ph_y == '0);
    assign is_last = (row == RW'(LAST_R + F - 1)) && (col == CW'(LAST_C + F - 1));
    assign is_end  = (row == RW'(IMAGE_HEIGHT - 1)) && (col == CW'(IMAGE_WIDTH - 1));

    // tap[F-1] is the live row; each line buffer pushes its output one row further up.
    assign tap[F-1] = in_data;

    for (genvar i = 0; i < F - 1; i++) begin : g_lb
        cnn_line_buffer #(
            .DATA_W (PW),
            .DEPTH  (IMAGE_WIDTH)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (tap[F-1-i]),
            .dout (tap[F-2-i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            ph_x <= '0;
            ph_y <= '0;
        end else if (accept) begin
            if (col == CW'(IMAGE_WIDTH - 1)) begin
                col  <= '0;
                ph_x <= '0;
                if (row == RW'(IMAGE_HEIGHT - 1)) begin
                    row  <= '0;
                    ph_y <= '0;
                end else begin
                    row <= row + 1'b1;
                    if (row >= RW'(F - 1)) begin
                        ph_y <= (ph_y == YPW'(STRIDE_Y - 1)) ? '0 : ph_y + 1'b1;
                    end
                end
            end else begin
                col <= col + 1'b1;
                if (col >= CW'(F - 1)) begin
                    ph_x <= (ph_x == XPW'(STRIDE_X - 1)) ? '0 : ph_x + 1'b1;
                end
            end
        end
    end

    // Column shift: index F-1 is the newest column, index 0 the leftmost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][F-1] <= tap[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_valid <= 1'b0;
            window_last  <= 1'b0;
            window_row   <= '0;
            window_col   <= '0;
            frame_done   <= 1'b0;
        end else if (clk_en) begin
            window_valid <= emit;
            window_last  <= emit && is_last;
            frame_done   <= accept && is_end;
            if (emit) begin
                window_row <= row - RW'(F - 1);
                window_col <= col - CW'(F - 1);
            end
        end
    end

    always_comb begin
        window_data = '0;
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F; c++) begin
                window_data[(r*F+c)*PW +: PW] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_stream.sv
// Scoreboard bench: a small 8x6 F=3 instance for directed scenarios and a default-sized
// instance fed random pixels; windows are predicted on accept and compared on consumption.
module tb_conv_window_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_en, s_vld;
    logic [7:0]  s_din;
    logic [71:0] s_wdat;
    logic        s_wvld, s_wlast, s_fdone;
    logic [2:0]  s_wrow, s_wcol;

    logic         d_rst, d_en, d_vld;
    logic [23:0]  d_din;
    logic [599:0] d_wdat;
    logic         d_wvld, d_wlast, d_fdone;
    logic [4:0]   d_wrow;
    logic [5:0]   d_wcol;

    conv_window_stream #(
        .I_WIDTH      (8),
        .CHANNELS_IN  (1),
        .FILTER_SIZE  (3),
        .IMAGE_WIDTH  (8),
        .IMAGE_HEIGHT (6),
        .STRIDE_X     (2),
        .STRIDE_Y     (1)
    ) u_small (
        .clk          (clk),
        .rst          (s_rst),
        .clk_en       (s_en),
        .in_valid     (s_vld),
        .in_data      (s_din),
        .window_data  (s_wdat),
        .window_valid (s_wvld),
        .window_row   (s_wrow),
        .window_col   (s_wcol),
        .window_last  (s_wlast),
        .frame_done   (s_fdone)
    );

    conv_window_stream u_dflt (
        .clk          (clk),
        .rst          (d_rst),
        .clk_en       (d_en),
        .in_valid     (d_vld),
        .in_data      (d_din),
        .window_data  (d_wdat),
        .window_valid (d_wvld),
        .window_row   (d_wrow),
        .window_col   (d_wcol),
        .window_last  (d_wlast),
        .frame_done   (d_fdone)
    );

    typedef struct {
        logic [599:0] dat;
        int           row;
        int           col;
        bit           last;
        int           due;
    } exp_t;

    exp_t        q[$];
    logic [23:0] img [32][64];
    int          m_r = 0, m_c = 0, edges = 0, fd_due = -1, seen = 0;
    int          n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [23:0] pix(input int p);
        return 24'((p / 8) * 16 + (p % 8));
    endfunction

    // One clock: drive the selected DUT, check what it produced on the previous edge,
    // then advance the reference model.
    task automatic step(input int sel, input bit rst, input bit en, input bit vld,
                        input logic [23:0] din);
        int f, w, h, sx, sy, pw, lr, lc, orow, ocol;
        logic ov, olast, ofd;
        logic [599:0] odat;
        bit efd;
        exp_t e;
        f  = sel ? 5 : 3;   w  = sel ? 64 : 8;  h  = sel ? 32 : 6;
        sx = sel ? 4 : 2;   sy = sel ? 4 : 1;   pw = sel ? 24 : 8;
        lr = ((h - f) / sy) * sy;
        lc = ((w - f) / sx) * sx;
        if (sel == 0) begin
            s_rst = rst; s_en = en; s_vld = vld; s_din = din[7:0];
            d_en = 1'b0; d_vld = 1'b0;
            ov = s_wvld; odat = 600'(s_wdat); orow = int'(s_wrow); ocol = int'(s_wcol);
            olast = s_wlast; ofd = s_fdone;
        end else begin
            d_rst = rst; d_en = en; d_vld = vld; d_din = din;
            s_en = 1'b0; s_vld = 1'b0;
            ov = d_wvld; odat = d_wdat; orow = int'(d_wrow); ocol = int'(d_wcol);
            olast = d_wlast; ofd = d_fdone;
        end

        if (ov === 1'b1) begin
            if (q.size() == 0) begin
                if (en) check("spurious_vld", 600'(ov), 600'(0));
            end else begin
                e = q[0];
                check("win_data", odat, e.dat);
                check("win_pos", {olast, orow, ocol}, {e.last, e.row, e.col});
                if (en) begin
                    check("win_latency", 600'(edges), 600'(e.due));
                    void'(q.pop_front());
                    seen++;
                end
            end
        end
        efd = (edges == fd_due);
        if (ofd === 1'b1 || efd) check("frame_done", 600'(ofd), 600'(efd));

        if (rst) begin
            m_r = 0; m_c = 0; fd_due = -1;
            q.delete();
        end else if (en && vld) begin
            img[m_r][m_c] = din;
            if (m_r >= f - 1 && m_c >= f - 1 &&
                (m_r - f + 1) % sy == 0 && (m_c - f + 1) % sx == 0) begin
                e.dat = '0;
                for (int r = 0; r < f; r++)
                    for (int c = 0; c < f; c++)
                        e.dat |= 600'(img[m_r-f+1+r][m_c-f+1+c]) << ((r * f + c) * pw);
                e.row  = m_r - f + 1;
                e.col  = m_c - f + 1;
                e.last = (e.row == lr) && (e.col == lc);
                e.due  = edges + 1;
                q.push_back(e);
            end
            if (m_r == h - 1 && m_c == w - 1) fd_due = edges + 1;
            if (m_c == w - 1) begin
                m_c = 0;
                m_r = (m_r == h - 1) ? 0 : m_r + 1;
            end else begin
                m_c++;
            end
        end
        if (en) edges++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input int sel);
        if (sel == 0) begin
            check("rst_vld", 600'(s_wvld), 600'(0));
            check("rst_dat", 600'(s_wdat), 600'(0));
            check("rst_misc", 600'({s_wlast, s_fdone, s_wrow, s_wcol}), 600'(0));
        end else begin
            check("rst_vld_d", 600'(d_wvld), 600'(0));
            check("rst_dat_d", d_wdat, 600'(0));
            check("rst_misc_d", 600'({d_wlast, d_fdone, d_wrow, d_wcol}), 600'(0));
        end
    endtask

    task automatic phase_end(input string tag, input int want);
        check(tag, 600'(seen), 600'(want));
        check("queue_empty", 600'(q.size()), 600'(0));
        seen = 0;
    endtask

    initial begin
        s_rst = 1'b1; s_en = 1'b0; s_vld = 1'b0; s_din = '0;
        d_rst = 1'b1; d_en = 1'b0; d_vld = 1'b0; d_din = '0;
        @(negedge clk);

        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk_zero(0);

        // Two back-to-back frames with in_valid held high.
        for (int p = 0; p < 96; p++) step(0, 0, 1, 1, pix(p % 48));
        step(0, 0, 1, 0, 0);
        phase_end("cnt_2frames", 24);

        // in_valid toggling every cycle.
        for (int p = 0; p < 48; p++) begin
            step(0, 0, 1, 1, pix(p));
            step(0, 0, 1, 0, 0);
        end
        phase_end("cnt_toggle", 12);

        // clk_en low for 5 cycles right after 0x24 is accepted; in_valid garbage meanwhile.
        for (int p = 0; p < 48; p++) begin
            step(0, 0, 1, 1, pix(p));
            if (p == 20) repeat (5) step(0, 0, 0, 1, 24'hFF);
        end
        step(0, 0, 1, 0, 0);
        phase_end("cnt_clken", 12);

        // Partial frame with distinct data, reset after 0x33, then a clean frame.
        for (int p = 0; p <= 27; p++) step(0, 0, 1, 1, pix(p) ^ 24'h80);
        step(0, 1, 1, 0, 0);
        chk_zero(0);
        seen = 0;
        for (int p = 0; p < 48; p++) step(0, 0, 1, 1, pix(p));
        step(0, 0, 1, 0, 0);
        phase_end("cnt_after_rst", 12);

        // Default-sized instance, random pixels with random input gaps.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk_zero(1);
        seen = 0;
        for (int p = 0; p < 2048; p++) begin
            if ($urandom_range(0, 3) == 0) step(1, 0, 1, 0, 0);
            step(1, 0, 1, 1, 24'($urandom()));
        end
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        phase_end("cnt_default", 105);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
